seven_seg_scanner: RTL and testbench

- Drives the 4-digit, common-anode seven-segment display from the 20-bit packed BCD score produced by the binary-to-BCD converter.
- Takes one snapshot of the score per frame, then time-multiplexes the four digits through a prescaled refresh counter.
- Blanks leading zeros and inserts an anode-off guard interval at the start of each digit slot to suppress ghosting.
- Saturates the display to 9999 when the fifth BCD digit is nonzero.

---
 rtl/seven_seg_scanner_if.sv | 26 ++
 rtl/seven_seg_scanner.sv | 100 ++++++++++
 tb/tb_seven_seg_scanner.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scanner_if.sv
// Display-side signal bundle for the seven-segment scanner.
//   BCD       : packed 5-digit BCD score (units in [3:0])
//   Enable    : 0 blanks the display, timing keeps running
//   An        : anode enables, active-low, An[0] = units digit
//   Seg       : segments {CG..CA}, active-low
//   Dp        : decimal point, active-low
//   FrameDone : one-cycle pulse at the start of each frame
// master = score source / display consumer, slave = scanner.
interface seven_seg_scanner_if;
  logic [19:0] BCD;
  logic        Enable;
  logic [3:0]  An;
  logic [6:0]  Seg;
  logic        Dp;
  logic        FrameDone;

  modport master (
    output BCD, Enable,
    input  An, Seg, Dp, FrameDone
  );

  modport slave (
    input  BCD, Enable,
    output An, Seg, Dp, FrameDone
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// Four-digit common-anode seven-segment scanner.
// Takes one saturated snapshot of the BCD score per frame and multiplexes
// the four digits in fixed-length slots. Each slot starts with GUARD dark
// cycles to suppress ghosting. Leading zeros are blanked; digit 0 is
// always shown.
// Ports:
//   Clk     : system clock
//   Reset_n : synchronous active-low reset
//   disp    : seven_seg_scanner_if.slave (BCD/Enable in, An/Seg/Dp/FrameDone out)
module seven_seg_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 4
) (
  input logic                Clk,
  input logic                Reset_n,
  seven_seg_scanner_if.slave disp
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   snap_q, snap_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          fd_q, fd_d;

  logic          wrap;
  logic [3:0]    nib;
  logic          blank;
  logic          dark;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;  // non-BCD nibble shows a dash
    endcase
  endfunction

  always_comb begin
    wrap   = (cnt_q == CNT_LAST);
    cnt_d  = wrap ? '0 : cnt_q + CW'(1);
    idx_d  = wrap ? idx_q + 2'd1 : idx_q;
    snap_d = snap_q;
    // Snapshot on the edge that closes slot 3, i.e. the first edge of a frame.
    if (wrap && idx_q == 2'd3) begin
      snap_d = (disp.BCD[19:16] != 4'd0) ? 16'h9999 : disp.BCD[15:0];
    end

    // A digit is blanked when it and every more-significant digit is zero.
    nib   = snap_q[3:0];
    blank = 1'b0;
    case (idx_q)
      2'd0: begin nib = snap_q[3:0];   blank = 1'b0;                   end
      2'd1: begin nib = snap_q[7:4];   blank = (snap_q[15:4]  == '0);  end
      2'd2: begin nib = snap_q[11:8];  blank = (snap_q[15:8]  == '0);  end
      default: begin nib = snap_q[15:12]; blank = (snap_q[15:12] == '0); end
    endcase

    dark  = !disp.Enable || (cnt_q < CNT_GUARD) || blank;
    an_d  = dark ? 4'b1111 : ~(4'b0001 << idx_q);
    seg_d = dark ? 7'b1111111 : decode(nib);
    fd_d  = (idx_q == 2'd0) && (cnt_q == '0);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      cnt_q  <= '0;
      idx_q  <= 2'd0;
      snap_q <= 16'h0000;
      an_q   <= 4'b1111;
      seg_q  <= 7'b1111111;
      fd_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      fd_q   <= fd_d;
    end
  end

  assign disp.An        = an_q;
  assign disp.Seg       = seg_q;
  assign disp.Dp        = 1'b1;
  assign disp.FrameDone = fd_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner with REFRESH_DIV=8, GUARD=2.
// Expected per-cycle outputs of a whole frame are pushed to a scoreboard
// queue from a behavioural model, then popped and compared cycle by cycle.
module tb_seven_seg_scanner;
  localparam int RD = 8;
  localparam int GD = 2;
  localparam int FRAME = 4 * RD;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       fd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  seven_seg_scanner_if sif ();

  seven_seg_scanner #(.REFRESH_DIV(RD), .GUARD(GD)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .disp    (sif)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: seg_of = 7'b1000000;
      4'h1: seg_of = 7'b1111001;
      4'h2: seg_of = 7'b0100100;
      4'h3: seg_of = 7'b0110000;
      4'h4: seg_of = 7'b0011001;
      4'h5: seg_of = 7'b0010010;
      4'h6: seg_of = 7'b0000010;
      4'h7: seg_of = 7'b1111000;
      4'h8: seg_of = 7'b0000000;
      4'h9: seg_of = 7'b0010000;
      default: seg_of = 7'b0111111;
    endcase
  endfunction

  // Expected outputs at offset o of a frame (o=0 is the FrameDone cycle).
  function automatic exp_t model(input logic [19:0] bcd, input int o, input bit en_dark);
    logic [15:0] snap;
    int s, j, msd;
    exp_t e;
    snap = (bcd[19:16] != 4'h0) ? 16'h9999 : bcd[15:0];
    s = o / RD;
    j = o % RD;
    msd = 0;
    for (int k = 0; k < 4; k++) if (snap[4*k +: 4] != 4'h0) msd = k;
    e.fd  = (o == 0);
    e.an  = 4'b1111;
    e.seg = 7'b1111111;
    if (j >= GD && s <= msd && !en_dark) begin
      case (s)
        0: e.an = 4'b1110;
        1: e.an = 4'b1101;
        2: e.an = 4'b1011;
        default: e.an = 4'b0111;
      endcase
      e.seg = seg_of(snap[4*s +: 4]);
    end
    return e;
  endfunction

  // Waits (bounded) for a FrameDone pulse; returns cycles waited.
  task automatic wait_fd(input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sif.FrameDone && n < FRAME + 8);
    total++;
    if (sif.FrameDone !== 1'b1) begin
      bad++;
      $display("FAIL %s fd_timeout: FrameDone=%b after %0d cycles, expected 1", name, sif.FrameDone, n);
    end
  endtask

  // Checks a full frame starting at the current negedge (FrameDone cycle).
  task automatic check_frame(input logic [19:0] bcd, input string name,
                             input int chg_at, input logic [19:0] chg_val, input int en_at);
    exp_t e;
    for (int o = 0; o < FRAME; o++)
      sb.push_back(model(bcd, o, (en_at >= 0 && o >= en_at + 1 && o <= en_at + 5)));
    for (int o = 0; o < FRAME; o++) begin
      if (o > 0) @(negedge clk);
      if (o == chg_at) sif.BCD = chg_val;
      if (en_at >= 0 && o == en_at) sif.Enable = 1'b0;
      if (en_at >= 0 && o == en_at + 5) sif.Enable = 1'b1;
      e = sb.pop_front();
      total++;
      if (sif.An !== e.an) begin
        bad++;
        $display("FAIL %s an o=%0d: got %b expected %b", name, o, sif.An, e.an);
      end
      total++;
      if (sif.Seg !== e.seg) begin
        bad++;
        $display("FAIL %s seg o=%0d: got %b expected %b", name, o, sif.Seg, e.seg);
      end
      total++;
      if (sif.FrameDone !== e.fd) begin
        bad++;
        $display("FAIL %s fd o=%0d: got %b expected %b", name, o, sif.FrameDone, e.fd);
      end
      total++;
      if (sif.Dp !== 1'b1) begin
        bad++;
        $display("FAIL %s dp o=%0d: got %b expected 1", name, o, sif.Dp);
      end
    end
  endtask

  // Loads a score and checks the first frame guaranteed to use it.
  task automatic show(input logic [19:0] bcd, input string name);
    int n;
    sif.BCD = bcd;
    wait_fd(name, n);
    repeat (FRAME) @(negedge clk);
    check_frame(bcd, name, -1, 20'h0, -1);
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    sif.BCD = 20'h01234;
    sif.Enable = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (sif.An !== 4'b1111 || sif.Seg !== 7'b1111111 || sif.Dp !== 1'b1 || sif.FrameDone !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold c=%0d: got An=%b Seg=%b Dp=%b FD=%b expected 1111 1111111 1 0",
                 c, sif.An, sif.Seg, sif.Dp, sif.FrameDone);
      end
    end
    rst_n = 1'b1;
    wait_fd("reset_first_fd", n);
    total++;
    if (n != 1) begin
      bad++;
      $display("FAIL reset_fd_latency: got %0d cycles expected 1", n);
    end
    check_frame(20'h00000, "reset_frame0", -1, 20'h0, -1);
    @(negedge clk);
    check_frame(20'h01234, "reset_frame1", -1, 20'h0, -1);
  endtask

  task automatic test_scan();
    show(20'h01234, "scan_1234");
  endtask

  task automatic test_blanking();
    show(20'h00007, "blank_7");
    show(20'h00105, "blank_105");
    show(20'h00000, "blank_0");
  endtask

  task automatic test_saturation();
    show(20'h16383, "sat_16383");
    show(20'h0000A, "dash_A");
  endtask

  task automatic test_snapshot();
    show(20'h00012, "snap_pre");
    @(negedge clk);
    check_frame(20'h00012, "snap_hold", RD + 4, 20'h00034, -1);
    @(negedge clk);
    check_frame(20'h00034, "snap_new", -1, 20'h0, -1);
  endtask

  task automatic test_enable();
    @(negedge clk);
    check_frame(20'h00034, "enable_drop", -1, 20'h0, 5);
    @(negedge clk);
    check_frame(20'h00034, "enable_after", -1, 20'h0, -1);
  endtask

  task automatic test_reset_midframe();
    int n;
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_fd("midreset_fd", n);
    total++;
    if (n != 1) begin
      bad++;
      $display("FAIL midreset_fd_latency: got %0d cycles expected 1", n);
    end
    check_frame(20'h00000, "midreset_frame0", -1, 20'h0, -1);
    @(negedge clk);
    check_frame(20'h00034, "midreset_frame1", -1, 20'h0, -1);
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blanking();
    test_saturation();
    test_snapshot();
    test_enable();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
